matrix_dsp_sequencer: RTL and testbench
=======================================

MATRIX_DSP_SEQUENCER -- requirements
Module: matrix_dsp_sequencer

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 4, number of DSP axis units driven in lockstep.
REQ-002 SHALL have parameter MICROCODE_SIZE, default 256, program words per unit; last valid address is MICROCODE_SIZE-1.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  run request.
REQ-006 SHALL have port cmd_ready  output  1  high only in IDLE.
REQ-007 SHALL have port cmd_start_pc  input  8  first instruction address, sampled on accept.
REQ-008 SHALL have port abort  input  1  level request to stop the run.
REQ-009 SHALL have port program_counter  output  8  address broadcast to all units.
REQ-010 SHALL have port instruction_grab  output  1  instruction-memory read enable broadcast to all units.
REQ-011 SHALL have port submit  output  1  single-cycle issue strobe broadcast to all units.
REQ-012 SHALL have port unit_ready  input  NUM_UNITS  per-unit ready.
REQ-013 SHALL have port unit_program_ready  input  NUM_UNITS  per-unit end-of-program decode (opcode 7).
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at run end.
REQ-016 SHALL have port status  output  2  0 ok, 1 desync, 2 overrun, 3 aborted; valid with done, held until next accept.
REQ-017 SHALL have port step_count  output  9  instructions issued in the current or last run.

Function
REQ-018 SHALL implement states IDLE, FETCH, DECODE, ISSUE, HOLD, WAIT, DONE.
REQ-019 IDLE: cmd_valid high -> load program_counter=cmd_start_pc, clear step_count and status, go to FETCH.
REQ-020 FETCH: instruction_grab=1 for exactly one cycle, then DECODE; instruction_grab SHALL be 0 in every other state so the decoded fields stay stable.
REQ-021 DECODE: all unit_program_ready bits 1 -> DONE with status 0; some but not all bits 1 -> DONE with status 1; none -> ISSUE.
REQ-022 ISSUE: remain until all unit_ready bits are 1, then assert submit for one cycle and go to HOLD.
REQ-023 HOLD: one cycle; unit_ready SHALL be ignored there because units still report ready during their start cycle; then WAIT.
REQ-024 WAIT: when all unit_ready bits are 1, increment step_count; if program_counter==MICROCODE_SIZE-1 go to DONE with status 2, else increment program_counter and go to FETCH.
REQ-025 DONE: done=1 for one cycle, then IDLE.
REQ-026 Minimum instruction cadence SHALL be 5 cycles (FETCH, DECODE, ISSUE, HOLD, WAIT) when units are ready immediately.
REQ-027 abort high in FETCH, DECODE or ISSUE SHALL go to DONE with status 3 without asserting submit.
REQ-028 abort in HOLD or WAIT SHALL let the in-flight operation complete (all units ready), then go to DONE with status 3 and leave program_counter unchanged.
REQ-029 If abort and a desync or overrun condition occur in the same cycle, abort SHALL take priority (status 3).
REQ-030 step_count SHALL saturate at 511.
REQ-031 cmd_valid outside IDLE SHALL be ignored; a new run SHALL begin no earlier than the cycle after done.

Reset
REQ-032 Reset SHALL force IDLE, program_counter=0, instruction_grab=0, submit=0, done=0, busy=0, status=0, step_count=0.
REQ-033 Reset asserted mid-run SHALL drop submit and instruction_grab immediately (asynchronously) and SHALL NOT pulse done.

Structure
REQ-034 State encoding, status codes and the end-of-program opcode value (7) SHALL be defined in the shared matrix DSP package.
REQ-035 SHALL be a single module with no sub-modules; the all-units reduction SHALL be a plain AND over unit_ready.

Verification
REQ-036 start_pc=0x10, all units ready, end opcode at 0x13 -> 3 submits at 5-cycle spacing, done with status 0, step_count=3.
REQ-037 unit_ready of unit 2 held low for 10 cycles after a submit -> program_counter stays, no second submit until the AND is high.
REQ-038 unit_program_ready=4'b0101 in DECODE -> done with status 1, no submit.
REQ-039 start_pc=0xFF, no end opcode -> one submit, then done with status 2.
REQ-040 abort pulsed during WAIT -> no further submit after ready returns, done with status 3; reset asserted during HOLD -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/matrix_dsp_sequencer_pkg.sv
// Shared matrix DSP definitions: state encoding, run status codes, opcodes and field widths.
package matrix_dsp_sequencer_pkg;

    localparam int unsigned PC_W     = 8;
    localparam int unsigned STEP_W   = 9;
    localparam int unsigned STATUS_W = 2;
    localparam int unsigned STATE_W  = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_FETCH  = 3'd1;
    localparam logic [STATE_W-1:0] ST_DECODE = 3'd2;
    localparam logic [STATE_W-1:0] ST_ISSUE  = 3'd3;
    localparam logic [STATE_W-1:0] ST_HOLD   = 3'd4;
    localparam logic [STATE_W-1:0] ST_WAIT   = 3'd5;
    localparam logic [STATE_W-1:0] ST_DONE   = 3'd6;

    localparam logic [STATUS_W-1:0] STATUS_OK      = 2'd0;
    localparam logic [STATUS_W-1:0] STATUS_DESYNC  = 2'd1;
    localparam logic [STATUS_W-1:0] STATUS_OVERRUN = 2'd2;
    localparam logic [STATUS_W-1:0] STATUS_ABORTED = 2'd3;

    // Opcode each unit decodes into its unit_program_ready bit.
    localparam logic [2:0] OPCODE_END = 3'd7;

    localparam logic [STEP_W-1:0] STEP_MAX = '1;

endpackage

// File: rtl/matrix_dsp_sequencer_if.sv
// Command, status and unit-broadcast signals between the sequencer (slave) and its host/units (master).
interface matrix_dsp_sequencer_if #(
    parameter int unsigned NUM_UNITS = 4
);
    import matrix_dsp_sequencer_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [PC_W-1:0]       cmd_start_pc;
    logic                  abort;
    logic [PC_W-1:0]       program_counter;
    logic                  instruction_grab;
    logic                  submit;
    logic [NUM_UNITS-1:0]  unit_ready;
    logic [NUM_UNITS-1:0]  unit_program_ready;
    logic                  busy;
    logic                  done;
    logic [STATUS_W-1:0]   status;
    logic [STEP_W-1:0]     step_count;

    modport master (
        output cmd_valid, cmd_start_pc, abort, unit_ready, unit_program_ready,
        input  cmd_ready, program_counter, instruction_grab, submit,
               busy, done, status, step_count
    );

    modport slave (
        input  cmd_valid, cmd_start_pc, abort, unit_ready, unit_program_ready,
        output cmd_ready, program_counter, instruction_grab, submit,
               busy, done, status, step_count
    );

endinterface

// File: rtl/matrix_dsp_sequencer.sv
// Lockstep microcode sequencer: fetches, decodes and issues one instruction at a time to all DSP units.
module matrix_dsp_sequencer
    import matrix_dsp_sequencer_pkg::*;
#(
    parameter int unsigned NUM_UNITS      = 4,
    parameter int unsigned MICROCODE_SIZE = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    matrix_dsp_sequencer_if.slave bus
);

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(MICROCODE_SIZE - 1);

    logic [NUM_UNITS-1:0] unit_ready;
    logic [NUM_UNITS-1:0] unit_end;
    logic                 all_ready;
    logic                 all_end;
    logic                 any_end;

    logic [STATE_W-1:0]  state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [STATUS_W-1:0] status_q, status_d;
    logic                abort_q, abort_d;

    logic cmd_ready_q, busy_q, grab_q, submit_q, done_q;

    assign unit_ready = bus.unit_ready;
    assign unit_end   = bus.unit_program_ready;
    assign all_ready  = &unit_ready;
    assign all_end    = &unit_end;
    assign any_end    = |unit_end;

    // Next-state, counters and run status.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        step_d   = step_q;
        status_d = status_q;
        abort_d  = abort_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    pc_d     = bus.cmd_start_pc;
                    step_d   = '0;
                    status_d = STATUS_OK;
                    abort_d  = 1'b0;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.abort) begin
                    status_d = STATUS_ABORTED;
                    state_d  = ST_DONE;
                end else begin
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (bus.abort) begin
                    status_d = STATUS_ABORTED;
                    state_d  = ST_DONE;
                end else if (all_end) begin
                    status_d = STATUS_OK;
                    state_d  = ST_DONE;
                end else if (any_end) begin
                    status_d = STATUS_DESYNC;
                    state_d  = ST_DONE;
                end else begin
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.abort) begin
                    status_d = STATUS_ABORTED;
                    state_d  = ST_DONE;
                end else if (all_ready) begin
                    state_d  = ST_HOLD;
                end
            end
            // Units still report ready while starting, so HOLD only remembers an abort.
            ST_HOLD: begin
                abort_d = abort_q | bus.abort;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                abort_d = abort_q | bus.abort;
                if (all_ready) begin
                    step_d = (step_q == STEP_MAX) ? step_q : step_q + STEP_W'(1);
                    if (abort_d) begin
                        status_d = STATUS_ABORTED;
                        state_d  = ST_DONE;
                    end else if (pc_q == PC_LAST) begin
                        status_d = STATUS_OVERRUN;
                        state_d  = ST_DONE;
                    end else begin
                        pc_d    = pc_q + PC_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset clears strobes immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            step_q      <= '0;
            status_q    <= STATUS_OK;
            abort_q     <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            grab_q      <= 1'b0;
            submit_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            step_q      <= step_d;
            status_q    <= status_d;
            abort_q     <= abort_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            busy_q      <= (state_d != ST_IDLE);
            grab_q      <= (state_d == ST_FETCH);
            submit_q    <= (state_q == ST_ISSUE) && (state_d == ST_HOLD);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign bus.cmd_ready        = cmd_ready_q;
    assign bus.busy             = busy_q;
    assign bus.instruction_grab = grab_q;
    assign bus.submit           = submit_q;
    assign bus.done             = done_q;
    assign bus.program_counter  = pc_q;
    assign bus.step_count       = step_q;
    assign bus.status           = status_q;

endmodule

// File: tb/tb_matrix_dsp_sequencer.sv
// Directed bench for matrix_dsp_sequencer: units and their end-of-program decode are modelled here.
module tb_matrix_dsp_sequencer;
    import matrix_dsp_sequencer_pkg::*;

    localparam int unsigned NU = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    matrix_dsp_sequencer_if #(.NUM_UNITS(NU)) bus ();

    matrix_dsp_sequencer #(.NUM_UNITS(NU), .MICROCODE_SIZE(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Microcode model: at end_addr the units whose end_pattern bit is set hold the end opcode.
    logic          prog_en;
    logic [7:0]    end_addr;
    logic [NU-1:0] end_pattern;

    always_comb begin
        bus.unit_program_ready = '0;
        for (int u = 0; u < NU; u++) begin
            bus.unit_program_ready[u] =
                (((prog_en && bus.program_counter == end_addr && end_pattern[u]) ? OPCODE_END : 3'd1)
                 == OPCODE_END);
        end
    end

    int checks = 0;
    int passes = 0;

    int         n_sub;
    int         n_grab;
    int         sub_t[$];
    bit         got_done;
    logic [1:0] done_st;

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [7:0] pc);
        for (int i = 0; i < 20 && bus.cmd_ready !== 1'b1; i++) step_cycle();
        bus.cmd_start_pc = pc;
        bus.cmd_valid    = 1'b1;
        step_cycle();
        bus.cmd_valid    = 1'b0;
    endtask

    // Observe the run until done or the cycle budget expires.
    task automatic watch(input int budget);
        n_sub    = 0;
        n_grab   = 0;
        got_done = 1'b0;
        done_st  = 2'bxx;
        sub_t.delete();
        for (int i = 0; i < budget; i++) begin
            if (bus.submit === 1'b1) begin
                n_sub++;
                sub_t.push_back(i);
            end
            if (bus.instruction_grab === 1'b1) n_grab++;
            if (bus.done === 1'b1) begin
                got_done = 1'b1;
                done_st  = bus.status;
                break;
            end
            step_cycle();
        end
    endtask

    task automatic wait_submit(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.submit === 1'b1) begin
                found = 1'b1;
                break;
            end
            step_cycle();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++; if (bus.program_counter !== 8'h00) $display("FAIL reset_pc got %h want 00", bus.program_counter); else passes++;
        checks++; if (bus.instruction_grab !== 1'b0) $display("FAIL reset_grab got %b want 0", bus.instruction_grab); else passes++;
        checks++; if (bus.submit !== 1'b0) $display("FAIL reset_submit got %b want 0", bus.submit); else passes++;
        checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passes++;
        checks++; if (bus.status !== 2'd0) $display("FAIL reset_status got %0d want 0", bus.status); else passes++;
        checks++; if (bus.step_count !== 9'd0) $display("FAIL reset_step got %0d want 0", bus.step_count); else passes++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step_cycle();
        checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", bus.cmd_ready); else passes++;
    endtask

    task automatic test_basic();
        int gap0, gap1;
        bus.unit_ready = '1;
        prog_en = 1'b1; end_addr = 8'h13; end_pattern = 4'b1111;
        start_run(8'h10);
        watch(100);
        gap0 = (sub_t.size() >= 2) ? sub_t[1] - sub_t[0] : -1;
        gap1 = (sub_t.size() >= 3) ? sub_t[2] - sub_t[1] : -1;
        checks++; if (got_done !== 1'b1) $display("FAIL basic_done got %b want 1", got_done); else passes++;
        checks++; if (n_sub !== 3) $display("FAIL basic_submits got %0d want 3", n_sub); else passes++;
        checks++; if (gap0 !== 5) $display("FAIL basic_gap0 got %0d want 5", gap0); else passes++;
        checks++; if (gap1 !== 5) $display("FAIL basic_gap1 got %0d want 5", gap1); else passes++;
        checks++; if (n_grab !== 4) $display("FAIL basic_grab_cycles got %0d want 4", n_grab); else passes++;
        checks++; if (done_st !== 2'd0) $display("FAIL basic_status got %0d want 0", done_st); else passes++;
        checks++; if (bus.step_count !== 9'd3) $display("FAIL basic_step got %0d want 3", bus.step_count); else passes++;
        checks++; if (bus.program_counter !== 8'h13) $display("FAIL basic_pc got %h want 13", bus.program_counter); else passes++;
        step_cycle();
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL basic_idle busy=%b done=%b want 0 0", bus.busy, bus.done); else passes++;
    endtask

    task automatic test_stall();
        bit found, held_ok;
        bus.unit_ready = '1;
        prog_en = 1'b1; end_addr = 8'h22; end_pattern = 4'b1111;
        start_run(8'h20);
        wait_submit(found);
        checks++; if (found !== 1'b1) $display("FAIL stall_first_submit got %b want 1", found); else passes++;
        bus.unit_ready   = 4'b1011;
        bus.cmd_start_pc = 8'h99;
        bus.cmd_valid    = 1'b1;
        held_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step_cycle();
            if (bus.program_counter !== 8'h20 || bus.submit !== 1'b0) held_ok = 1'b0;
        end
        bus.cmd_valid  = 1'b0;
        checks++; if (held_ok !== 1'b1) $display("FAIL stall_hold got pc=%h submit=%b want pc=20 no submit", bus.program_counter, bus.submit); else passes++;
        bus.unit_ready = '1;
        watch(60);
        checks++; if (n_sub !== 1) $display("FAIL stall_second_submit got %0d want 1", n_sub); else passes++;
        checks++; if (done_st !== 2'd0) $display("FAIL stall_status got %0d want 0", done_st); else passes++;
        checks++; if (bus.step_count !== 9'd2) $display("FAIL stall_step got %0d want 2", bus.step_count); else passes++;
        checks++; if (bus.program_counter !== 8'h22) $display("FAIL stall_pc got %h want 22", bus.program_counter); else passes++;
    endtask

    task automatic test_desync();
        bus.unit_ready = '1;
        prog_en = 1'b1; end_addr = 8'h30; end_pattern = 4'b0101;
        start_run(8'h30);
        watch(20);
        checks++; if (n_sub !== 0) $display("FAIL desync_submits got %0d want 0", n_sub); else passes++;
        checks++; if (done_st !== 2'd1) $display("FAIL desync_status got %0d want 1", done_st); else passes++;
        checks++; if (bus.step_count !== 9'd0) $display("FAIL desync_step got %0d want 0", bus.step_count); else passes++;
        for (int i = 0; i < 3; i++) step_cycle();
        checks++; if (bus.status !== 2'd1) $display("FAIL desync_status_held got %0d want 1", bus.status); else passes++;
        checks++; if (bus.done !== 1'b0) $display("FAIL desync_done_pulse got %b want 0", bus.done); else passes++;
    endtask

    task automatic test_overrun();
        bus.unit_ready = '1;
        prog_en = 1'b0;
        start_run(8'hFF);
        watch(30);
        checks++; if (n_sub !== 1) $display("FAIL overrun_submits got %0d want 1", n_sub); else passes++;
        checks++; if (done_st !== 2'd2) $display("FAIL overrun_status got %0d want 2", done_st); else passes++;
        checks++; if (bus.step_count !== 9'd1) $display("FAIL overrun_step got %0d want 1", bus.step_count); else passes++;
        checks++; if (bus.program_counter !== 8'hFF) $display("FAIL overrun_pc got %h want FF", bus.program_counter); else passes++;
    endtask

    task automatic test_abort_wait();
        bit found, busy_ok;
        bus.unit_ready = '1;
        prog_en = 1'b0;
        start_run(8'h40);
        wait_submit(found);
        bus.unit_ready = '0;
        step_cycle();
        bus.abort = 1'b1;
        step_cycle();
        bus.abort = 1'b0;
        busy_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step_cycle();
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) busy_ok = 1'b0;
        end
        checks++; if (busy_ok !== 1'b1) $display("FAIL abort_wait_early_done busy=%b done=%b want 1 0", bus.busy, bus.done); else passes++;
        bus.unit_ready = '1;
        watch(20);
        checks++; if (n_sub !== 0) $display("FAIL abort_wait_submits got %0d want 0", n_sub); else passes++;
        checks++; if (done_st !== 2'd3) $display("FAIL abort_wait_status got %0d want 3", done_st); else passes++;
        checks++; if (bus.program_counter !== 8'h40) $display("FAIL abort_wait_pc got %h want 40", bus.program_counter); else passes++;
        checks++; if (bus.step_count !== 9'd1) $display("FAIL abort_wait_step got %0d want 1", bus.step_count); else passes++;
    endtask

    task automatic test_abort_priority();
        bus.unit_ready = '1;
        prog_en = 1'b1; end_addr = 8'h60; end_pattern = 4'b0101;
        start_run(8'h60);
        step_cycle();
        bus.abort = 1'b1;
        watch(10);
        bus.abort = 1'b0;
        checks++; if (got_done !== 1'b1) $display("FAIL abort_prio_done got %b want 1", got_done); else passes++;
        checks++; if (n_sub !== 0) $display("FAIL abort_prio_submits got %0d want 0", n_sub); else passes++;
        checks++; if (done_st !== 2'd3) $display("FAIL abort_prio_status got %0d want 3", done_st); else passes++;
    endtask

    task automatic test_reset_hold();
        bit found;
        int n_done;
        bus.unit_ready = '1;
        prog_en = 1'b0;
        start_run(8'h50);
        wait_submit(found);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (found !== 1'b1) $display("FAIL rst_hold_reached got %b want 1", found); else passes++;
        checks++; if (bus.submit !== 1'b0) $display("FAIL rst_hold_submit got %b want 0", bus.submit); else passes++;
        checks++; if (bus.instruction_grab !== 1'b0) $display("FAIL rst_hold_grab got %b want 0", bus.instruction_grab); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL rst_hold_busy got %b want 0", bus.busy); else passes++;
        checks++; if (bus.program_counter !== 8'h00) $display("FAIL rst_hold_pc got %h want 00", bus.program_counter); else passes++;
        checks++; if (bus.step_count !== 9'd0) $display("FAIL rst_hold_step got %0d want 0", bus.step_count); else passes++;
        @(negedge clk);
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            step_cycle();
            if (bus.done === 1'b1) n_done++;
        end
        checks++; if (n_done !== 0) $display("FAIL rst_hold_done_pulses got %0d want 0", n_done); else passes++;
        checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL rst_hold_cmd_ready got %b want 1", bus.cmd_ready); else passes++;
    endtask

    initial begin
        reset            = 1'b1;
        bus.cmd_valid    = 1'b0;
        bus.cmd_start_pc = 8'h00;
        bus.abort        = 1'b0;
        bus.unit_ready   = '1;
        prog_en          = 1'b0;
        end_addr         = 8'h00;
        end_pattern      = '0;
        test_reset();
        test_basic();
        test_stall();
        test_desync();
        test_overrun();
        test_abort_wait();
        test_abort_priority();
        test_reset_hold();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d of %0d checks", checks, checks);
        $fatal(1);
    end

endmodule
